// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned DefDataBits = 8;
    localparam int unsigned DefSbTick   = 16;
    localparam int unsigned Oversample  = 16;
    localparam int unsigned StartMid    = 7;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx line plus a one-clock delayed copy for falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta_q, meta_d;
    logic rx_s_q, rx_s_d;
    logic rx_s_dly_q, rx_s_dly_d;

    always_comb begin
        meta_d     = rx;
        rx_s_d     = meta_q;
        rx_s_dly_d = rx_s_q;
    end

    // Reset to 1 so the idle-high line never produces a spurious edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_s_dly_q <= 1'b1;
        end else begin
            meta_q     <= meta_d;
            rx_s_q     <= rx_s_d;
            rx_s_dly_q <= rx_s_dly_d;
        end
    end

    assign rx_s = rx_s_q;
    assign fall = rx_s_dly_q & ~rx_s_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversamples rx with a 16x-baud tick and emits each byte with a done strobe.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DefDataBits,
    parameter int unsigned SB_TICK   = DefSbTick
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [3:0]    MidStart = 4'(StartMid);
    localparam logic [3:0]    LastTick = 4'(Oversample - 1);
    localparam logic [3:0]    StopLast = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] LastBit  = NW'(DATA_BITS - 1);

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    rx_state_e            state_q, state_d;
    logic [3:0]           s_q, s_d;
    logic [NW-1:0]        n_q, n_d;
    logic [DATA_BITS-1:0] b_q, b_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 frame_err_q, frame_err_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            dout_q      <= '0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Edge-triggered so a line held low (break) cannot retrigger.
                if (fall) begin
                    s_d     = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (s_q == MidStart) begin
                        if (!rx_s) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = StData;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (s_q == LastTick) begin
                        b_d = {rx_s, b_q[DATA_BITS-1:1]};
                        s_d = '0;
                        if (n_q == LastBit) begin
                            state_d = StStop;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (s_q == StopLast) begin
                        dout_d      = b_q;
                        frame_err_d = ~rx_s;
                        done_d      = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dout         = dout_q;
        rx_done_tick = done_q;
        frame_err    = frame_err_q;
        busy         = (state_q != StIdle);
    end

endmodule
